// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - two-pass write/read-back BIST initiator for a synchronous RAM
// Pass 1 writes the inverted pattern so every cell is driven to both values of each data bit.
module ram_bist #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_pattern,
    output logic              o_mem_write_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_write_data,
    input  logic [DATA_W-1:0] i_mem_read_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [3:0]        o_err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_CHK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] A_MAX = '1;

    state_t            r_state;
    logic              r_ph;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_pat;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [3:0]        r_err;

    logic              w_mismatch;
    logic [3:0]        w_err_next;

    function automatic logic [DATA_W-1:0] f_expect(
        input logic [DATA_W-1:0] p,
        input logic [ADDR_W-1:0] a,
        input logic              ph
    );
        logic [DATA_W-1:0] v;
        v = p ^ DATA_W'(a);
        return ph ? ~v : v;
    endfunction

    assign w_mismatch = (i_mem_read_data != f_expect(r_pat, r_addr, r_ph));
    assign w_err_next = (w_mismatch && r_err != 4'hF) ? r_err + 4'd1 : r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ph        <= 1'b0;
            r_addr      <= '0;
            r_pat       <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_err       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state     <= S_WRITE;
                        r_pat       <= i_pattern;
                        r_ph        <= 1'b0;
                        r_addr      <= '0;
                        r_we        <= 1'b1;
                        r_wdata     <= i_pattern;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_addr <= '0;
                        r_err       <= '0;
                    end
                end
                S_WRITE: begin
                    if (r_addr == A_MAX) begin
                        r_state <= S_RD_ADDR;
                        r_addr  <= '0;
                        r_we    <= 1'b0;
                        r_wdata <= '0;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_wdata <= f_expect(r_pat, r_addr + 1'b1, r_ph);
                    end
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_CHK;
                end
                S_RD_CHK: begin
                    r_err <= w_err_next;
                    // A zero count before this compare marks the first miscompare.
                    if (w_mismatch && r_err == 4'd0) begin
                        r_fail_addr <= r_addr;
                    end
                    if (r_addr != A_MAX) begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_RD_ADDR;
                    end else if (!r_ph) begin
                        r_ph    <= 1'b1;
                        r_addr  <= '0;
                        r_state <= S_WRITE;
                        r_we    <= 1'b1;
                        r_wdata <= f_expect(r_pat, '0, 1'b1);
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 4'd0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_write_en   = r_we;
    assign o_mem_addr       = r_addr;
    assign o_mem_write_data = r_wdata;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_fail_addr      = r_fail_addr;
    assign o_err_count      = r_err;

endmodule
